dac_uart_sequencer: RTL and testbench
=====================================

// Module: dac_uart_sequencer
// PURPOSE
//  Command-driven controller for the 8-bit parallel DAC (R-2R ladder). Parses 4-byte frames from
//  the UART receiver, updates waveform registers and answers ACK/NAK through the UART transmitter.
//  Generates triangle/sawtooth/square samples at a programmable rate. Runs entirely in the UART clock domain.
// PARAMETERS
//  DAC_W        8       DAC code width
//  DIV_W        16      sample-rate divider width
//  HDR          8'hA5   frame header byte
//  TIMEOUT_CYC  50000   inter-byte timeout, clk cycles
// PORTS
//  clk          in   1      system clock (UART clock domain)
//  rst          in   1      asynchronous reset, active-high
//  rx_data      in   8      received byte
//  rx_valid     in   1      one-cycle strobe, rx_data valid
//  tx_data      out  8      response byte
//  tx_start     out  1      one-cycle transmit request
//  tx_busy      in   1      transmitter busy
//  dac_out      out  DAC_W  registered DAC code
//  sample_tick  out  1      one-cycle pulse per sample update
//  err          out  1      one-cycle pulse: bad checksum/opcode, timeout, or response overrun
// BEHAVIOUR
//  Reset values: dac_out=0, tx_data=0, tx_start=0, sample_tick=0, err=0. Internal: mode=OFF, step=1,
//   amp=8'hFF, div=999, acc=0, dir=up.
//  Frame: HDR, OP, VAL, CHK, with CHK = OP ^ VAL. Parser FSM: IDLE -> GOT_HDR -> GOT_OP -> GOT_VAL -> IDLE.
//   In IDLE, any non-HDR byte is ignored silently.
//  Checksum byte: on a good CHK, execute OP and queue ACK 8'h06; otherwise queue NAK 8'h15 and pulse err.
//   Register write takes effect on the cycle after the CHK strobe.
//  Timeout: in a non-IDLE state, TIMEOUT_CYC cycles with no rx_valid -> IDLE and pulse err; no response sent.
//  Opcodes:
//   0x01 MODE: VAL[1:0], 0=OFF 1=TRI 2=SAW 3=SQR.
//   0x02 STEP: VAL=0 is stored as 1.
//   0x03 DIV_HI: writes a shadow register.
//   0x04 DIV_LO: div = {shadow, VAL}.
//   0x05 AMP.
//   Any other opcode -> NAK.
//  Response path: one-entry pending slot. When pending && !tx_busy, drive tx_start=1 for exactly 1 cycle
//   with tx_data stable, then ignore tx_busy for 2 cycles (busy-assertion latency).
//   Frame completing while the slot is full: new response dropped, err pulses, register write still executes.
//  Divider: counter counts 0..div. sample_tick pulses on wrap, so the period is div+1 cycles; div=0 gives a
//   tick every cycle. Writing div reloads the counter to 0.
//  Accumulator: acc+step computed in DAC_W+1 bits; no wrap-through.
//   TRI: up until acc+step>=amp, then acc=amp and dir=down; down until acc<step, then acc=0 and dir=up.
//   SAW: if acc+step>amp then acc=0, else acc+=step.
//   SQR: acc runs as SAW; dac_out = (acc >= amp>>1) ? amp : 0.
//   OFF: acc=0, dac_out=0.
//  dac_out updates on the cycle after sample_tick. Any MODE write clears acc to 0 and dir to up.
//  amp=0: dac_out stays 0 in all modes.
//  Simultaneous rx_valid and tick: both processed in the same cycle; the register write applies to the next tick.
//  rst mid-frame or mid-transmit: everything returns to reset values immediately; tx_start deasserts.
// CONFIGURATION
//  DAC_SEQ_READBACK_EN defined: OP 0x81..0x85 with a valid CHK returns the current value of register OP&0x7F
//   (DIV_HI/DIV_LO return the live div bytes) instead of ACK; no register write.
//  DAC_SEQ_READBACK_EN undefined: 0x81..0x85 -> NAK + err.
// STRUCTURE
//  Package dac_seq_pkg: opcode localparams, ACK/NAK codes, mode encoding, parser/tx state encodings.
//  Sub-module dac_wave_gen: divider, accumulator, mode logic, dac_out register.
//   Top level holds the parser, register file and response slot.
// TESTING
//  Frame A5 01 01 00, then A5 02 10 12: tx ACK 06 twice; TRI with amp=FF, div=999 -> dac_out 0,16,..,240,255,239..
//  Frame A5 05 80 85 with CHK replaced by 84: NAK 15, err pulse, amp unchanged at FF.
//  A5 01, then silence for 50000 cycles: err pulses once, no tx_start; next full frame ACKed normally.
//  SAW, step=0x40, amp=0x90, div=0: ticks every cycle, dac_out 0,40,80,0,40 repeating.
//  Hold tx_busy=1, send two valid frames: second response dropped, err pulses; release busy -> exactly one 06 sent.
//  Assert rst mid-frame while in TRI: dac_out=0, tx_start=0 at once; after release, MODE defaults to OFF.

Source files
------------

// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - shared opcodes, response codes and state encodings for the DAC sequencer
package dac_seq_pkg;
  localparam logic [7:0] OP_MODE   = 8'h01;
  localparam logic [7:0] OP_STEP   = 8'h02;
  localparam logic [7:0] OP_DIV_HI = 8'h03;
  localparam logic [7:0] OP_DIV_LO = 8'h04;
  localparam logic [7:0] OP_AMP    = 8'h05;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SAW = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_GOT_HDR = 2'd1,
    P_GOT_OP  = 2'd2,
    P_GOT_VAL = 2'd3
  } parse_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_HOLD1 = 2'd1,
    TX_HOLD2 = 2'd2
  } tx_e;
endpackage

// File: rtl/dac_wave_gen.sv
// rtl/dac_wave_gen.sv - sample-rate divider, waveform accumulator and registered DAC code
module dac_wave_gen
  import dac_seq_pkg::*;
#(
  parameter int DAC_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic [DAC_W-1:0] step_i,
  input  logic [DAC_W-1:0] amp_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_wr_i,
  input  logic             mode_wr_i,
  output logic [DAC_W-1:0] dac_o,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [DAC_W-1:0] acc_q, acc_d, acc_nx, dac_q, dac_d;
  logic             dir_q, dir_d, dir_nx;  // 0 = rising, 1 = falling
  logic [DAC_W:0]   sum;
  logic [DAC_W-1:0] half;

  // Divider wraps at div; a div write restarts the period from zero.
  always_comb begin
    tick_d = (cnt_q == div_i);
    if (div_wr_i || tick_d) cnt_d = '0;
    else                    cnt_d = cnt_q + DIV_W'(1);
  end

  // Waveform step on each tick; the extra sum bit keeps overflow from wrapping.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, step_i};
    half   = amp_i >> 1;
    acc_nx = acc_q;
    dir_nx = dir_q;
    case (mode_e'(mode_i))
      MODE_TRI: begin
        if (!dir_q) begin
          if (sum >= {1'b0, amp_i}) begin
            acc_nx = amp_i;
            dir_nx = 1'b1;
          end else begin
            acc_nx = sum[DAC_W-1:0];
          end
        end else if (acc_q < step_i) begin
          acc_nx = '0;
          dir_nx = 1'b0;
        end else begin
          acc_nx = acc_q - step_i;
        end
      end
      MODE_SAW, MODE_SQR: acc_nx = (sum > {1'b0, amp_i}) ? '0 : sum[DAC_W-1:0];
      default: begin
        acc_nx = '0;
        dir_nx = 1'b0;
      end
    endcase

    dac_d = dac_q;
    if (tick_q) begin
      case (mode_e'(mode_i))
        MODE_TRI, MODE_SAW: dac_d = acc_nx;
        MODE_SQR:           dac_d = (acc_nx >= half) ? amp_i : '0;
        default:            dac_d = '0;
      endcase
      if (amp_i == '0) dac_d = '0;
    end

    // A mode change restarts the shape from the bottom, rising.
    acc_d = mode_wr_i ? '0   : (tick_q ? acc_nx : acc_q);
    dir_d = mode_wr_i ? 1'b0 : (tick_q ? dir_nx : dir_q);
  end

  // Waveform state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      acc_q  <= '0;
      dir_q  <= 1'b0;
      dac_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      acc_q  <= acc_d;
      dir_q  <= dir_d;
      dac_q  <= dac_d;
    end
  end

  assign dac_o  = dac_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/dac_uart_sequencer.sv
// rtl/dac_uart_sequencer.sv - UART frame parser, register file and ACK/NAK slot; DAC_SEQ_READBACK_EN adds 0x81..0x85 readback
module dac_uart_sequencer
  import dac_seq_pkg::*;
#(
  parameter int         DAC_W       = 8,
  parameter int         DIV_W       = 16,
  parameter logic [7:0] HDR         = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_start_o,
  input  logic             tx_busy_i,
  output logic [DAC_W-1:0] dac_out_o,
  output logic             sample_tick_o,
  output logic             err_o
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  parse_e           pst_q, pst_d;
  tx_e              tst_q, tst_d;
  logic [7:0]       op_q, op_d, val_q, val_d, shadow_q, shadow_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       mode_q, mode_d;
  logic [DAC_W-1:0] step_q, step_d, amp_q, amp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_q, pend_d, tx_start_q, tx_start_d, err_q, err_d;
  logic [7:0]       pdata_q, pdata_d, tx_data_q, tx_data_d, rsp;
  logic             div_wr, mode_wr, frame_done, deq;

  // Parser, register writes and response slot; all decisions made on the byte strobe.
  always_comb begin
    pst_d = pst_q;      tst_d = tst_q;     op_d = op_q;       val_d = val_q;
    shadow_d = shadow_q; tmr_d = tmr_q;    mode_d = mode_q;   step_d = step_q;
    amp_d = amp_q;      div_d = div_q;     pend_d = pend_q;   pdata_d = pdata_q;
    tx_data_d = tx_data_q; tx_start_d = 1'b0; err_d = 1'b0;
    div_wr = 1'b0; mode_wr = 1'b0; frame_done = 1'b0; deq = 1'b0; rsp = RSP_NAK;

    // Launch one byte, then let the transmitter's busy flag catch up before looking again.
    case (tst_q)
      TX_IDLE: if (pend_q && !tx_busy_i) begin
        tx_start_d = 1'b1;
        tx_data_d  = pdata_q;
        deq        = 1'b1;
        tst_d      = TX_HOLD1;
      end
      TX_HOLD1: tst_d = TX_HOLD2;
      default:  tst_d = TX_IDLE;
    endcase
    if (deq) pend_d = 1'b0;

    if (rx_valid_i) begin
      tmr_d = '0;
      case (pst_q)
        P_IDLE:    if (rx_data_i == HDR) pst_d = P_GOT_HDR;
        P_GOT_HDR: begin op_d = rx_data_i; pst_d = P_GOT_OP; end
        P_GOT_OP:  begin val_d = rx_data_i; pst_d = P_GOT_VAL; end
        default: begin
          pst_d      = P_IDLE;
          frame_done = 1'b1;
          if (rx_data_i == (op_q ^ val_q)) begin
            rsp = RSP_ACK;
            case (op_q)
              OP_MODE:   begin mode_d = val_q[1:0]; mode_wr = 1'b1; end
              OP_STEP:   step_d = (val_q == 8'h00) ? DAC_W'(1) : DAC_W'(val_q);
              OP_DIV_HI: shadow_d = val_q;
              OP_DIV_LO: begin div_d = DIV_W'({shadow_q, val_q}); div_wr = 1'b1; end
              OP_AMP:    amp_d = DAC_W'(val_q);
`ifdef DAC_SEQ_READBACK_EN
              8'h81: rsp = {6'b0, mode_q};
              8'h82: rsp = 8'(step_q);
              8'h83: rsp = 8'(div_q >> 8);
              8'h84: rsp = 8'(div_q);
              8'h85: rsp = 8'(amp_q);
`endif
              default: begin rsp = RSP_NAK; err_d = 1'b1; end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (pst_q != P_IDLE) begin
      if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
        pst_d = P_IDLE;
        tmr_d = '0;
        err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end

    // A slot being launched this cycle counts as free; otherwise an occupied slot drops the reply.
    if (frame_done) begin
      if (pend_q && !deq) begin
        err_d = 1'b1;
      end else begin
        pend_d  = 1'b1;
        pdata_d = rsp;
      end
    end
  end

  // Control and register-file state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pst_q <= P_IDLE;   tst_q <= TX_IDLE;  op_q <= '0;        val_q <= '0;
      shadow_q <= '0;    tmr_q <= '0;       mode_q <= MODE_OFF; step_q <= DAC_W'(1);
      amp_q <= '1;       div_q <= DIV_W'(999); pend_q <= 1'b0; pdata_q <= '0;
      tx_data_q <= '0;   tx_start_q <= 1'b0; err_q <= 1'b0;
    end else begin
      pst_q <= pst_d;    tst_q <= tst_d;    op_q <= op_d;      val_q <= val_d;
      shadow_q <= shadow_d; tmr_q <= tmr_d; mode_q <= mode_d;  step_q <= step_d;
      amp_q <= amp_d;    div_q <= div_d;    pend_q <= pend_d;  pdata_q <= pdata_d;
      tx_data_q <= tx_data_d; tx_start_q <= tx_start_d; err_q <= err_d;
    end
  end

  dac_wave_gen #(.DAC_W(DAC_W), .DIV_W(DIV_W)) u_wave (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mode_i    (mode_q),
    .step_i    (step_q),
    .amp_i     (amp_q),
    .div_i     (div_q),
    .div_wr_i  (div_wr),
    .mode_wr_i (mode_wr),
    .dac_o     (dac_out_o),
    .tick_o    (sample_tick_o)
  );

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_dac_uart_sequencer.sv
// tb/tb_dac_uart_sequencer.sv - randomized self-checking bench with a behavioural DAC/UART model
module tb_dac_uart_sequencer;
  logic       clk, rst, rx_valid, tx_busy, tx_start, sample_tick, err;
  logic [7:0] rx_data, tx_data, dac_out;

  dac_uart_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .tx_data_o    (tx_data),
    .tx_start_o   (tx_start),
    .tx_busy_i    (tx_busy),
    .dac_out_o    (dac_out),
    .sample_tick_o(sample_tick),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register model, written only by the stimulus process.
  int m_mode, m_step, m_amp, m_div, m_shadow;
  int mode_wr_cnt = 0, div_wr_cnt = 0;
  int exp_rsp[$];
  int err_exp = 0;

  // Waveform model and event counters, owned by the monitor.
  int m_acc = 0, s, exp_dac, cyc = 0, last_tick = 0;
  bit m_down = 0, have_tick = 0, dac_pend = 0;
  int mode_wr_seen = 0, div_wr_seen = 0, rsp_rd = 0, err_seen = 0, tx_seen = 0;

  task automatic model_reset();
    m_mode = 0; m_step = 1; m_amp = 255; m_div = 999; m_shadow = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      dac_pend = 0; have_tick = 0; m_acc = 0; m_down = 0;
      mode_wr_seen = mode_wr_cnt; div_wr_seen = div_wr_cnt;
    end else begin
      if (dac_pend) begin
        check("dac_out", dac_out, exp_dac);
        dac_pend = 0;
      end
      if (mode_wr_seen != mode_wr_cnt) begin
        m_acc = 0; m_down = 0; mode_wr_seen = mode_wr_cnt;
      end
      if (sample_tick) begin
        if (have_tick && div_wr_seen == div_wr_cnt) check("tick_period", cyc - last_tick, m_div + 1);
        div_wr_seen = div_wr_cnt; have_tick = 1; last_tick = cyc;
        case (m_mode)
          1: begin
            if (!m_down) begin
              s = m_acc + m_step;
              if (s >= m_amp) begin m_acc = m_amp; m_down = 1; end
              else m_acc = s;
            end else if (m_acc < m_step) begin
              m_acc = 0; m_down = 0;
            end else m_acc = m_acc - m_step;
          end
          2, 3: begin s = m_acc + m_step; m_acc = (s > m_amp) ? 0 : s; end
          default: begin m_acc = 0; m_down = 0; end
        endcase
        if (m_mode == 0 || m_amp == 0) exp_dac = 0;
        else if (m_mode == 3)          exp_dac = (m_acc >= m_amp / 2) ? m_amp : 0;
        else                           exp_dac = m_acc;
        dac_pend = 1;
      end
      if (tx_start) begin
        tx_seen++;
        check("tx_expected", rsp_rd < exp_rsp.size(), 1);
        if (rsp_rd < exp_rsp.size()) begin
          check("tx_data", tx_data, exp_rsp[rsp_rd]);
          rsp_rd++;
        end
      end
      if (err) err_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic apply_frame(input logic [7:0] op, input logic [7:0] val, input logic [7:0] ck, input bit drop);
    int rsp;
    bit bad;
    send_byte(8'hA5); send_byte(op); send_byte(val); send_byte(ck);
    bad = 0;
    rsp = 8'h06;
    if (ck != (op ^ val)) bad = 1;
    else case (op)
      8'h01: begin m_mode = int'(val) & 3; mode_wr_cnt++; end
      8'h02: m_step = (val == 0) ? 1 : int'(val);
      8'h03: m_shadow = int'(val);
      8'h04: begin m_div = m_shadow * 256 + int'(val); div_wr_cnt++; end
      8'h05: m_amp = int'(val);
`ifdef DAC_SEQ_READBACK_EN
      8'h81: rsp = m_mode;
      8'h82: rsp = m_step;
      8'h83: rsp = m_div / 256;
      8'h84: rsp = m_div % 256;
      8'h85: rsp = m_amp;
`endif
      default: bad = 1;
    endcase
    if (bad) rsp = 8'h15;
    if (bad || drop) err_exp++;
    if (!drop) exp_rsp.push_back(rsp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base_err, base_tx, r;
    logic [7:0] op, val, ck;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    model_reset();
    wait_cyc(3);
    check("rst_dac", dac_out, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // TRI, step 16, amp FF at the default divider, then faster.
    apply_frame(8'h01, 8'h01, 8'h00, 0);
    apply_frame(8'h02, 8'h10, 8'h12, 0);
    wait_cyc(20);
    check("ack_count", tx_seen, 2);
    wait_cyc(3100);
    apply_frame(8'h03, 8'h00, 8'h03, 0);
    apply_frame(8'h04, 8'h03, 8'h07, 0);
    wait_cyc(200);

    // Bad checksum, unknown opcode, readback opcode.
    base_err = err_seen; base_tx = tx_seen;
    apply_frame(8'h05, 8'h80, 8'h84, 0);
    wait_cyc(10);
    check("nak_err", err_seen - base_err, 1);
    check("nak_tx", tx_seen - base_tx, 1);
    apply_frame(8'h07, 8'h05, 8'h02, 0);
    apply_frame(8'h85, 8'h00, 8'h85, 0);
    wait_cyc(40);

    // Inter-byte timeout.
    base_err = err_seen; base_tx = tx_seen;
    send_byte(8'hA5); send_byte(8'h01);
    wait_cyc(49990);
    check("timeout_early", err_seen - base_err, 0);
    wait_cyc(20);
    check("timeout_err", err_seen - base_err, 1);
    check("timeout_tx", tx_seen - base_tx, 0);
    err_exp++;
    apply_frame(8'h05, 8'hFF, 8'hFA, 0);
    wait_cyc(10);
    check("post_timeout_ack", tx_seen - base_tx, 1);

    // SAW with a tick every cycle.
    apply_frame(8'h01, 8'h02, 8'h03, 0);
    apply_frame(8'h02, 8'h40, 8'h42, 0);
    apply_frame(8'h05, 8'h90, 8'h95, 0);
    apply_frame(8'h03, 8'h00, 8'h03, 0);
    apply_frame(8'h04, 8'h00, 8'h04, 0);
    wait_cyc(30);

    // Slot overrun while the transmitter is busy.
    tx_busy = 1'b1;
    base_err = err_seen; base_tx = tx_seen;
    apply_frame(8'h05, 8'hC0, 8'hC5, 0);
    apply_frame(8'h02, 8'h20, 8'h22, 1);
    wait_cyc(10);
    check("busy_tx_held", tx_seen - base_tx, 0);
    check("busy_drop_err", err_seen - base_err, 1);
    @(negedge clk) tx_busy = 1'b0;
    wait_cyc(10);
    check("busy_one_sent", tx_seen - base_tx, 1);

    // Randomized frames.
    for (int i = 0; i < 60; i++) begin
      r   = $urandom_range(0, 9);
      val = 8'($urandom);
      case (r)
        0: op = 8'h01;
        1: op = 8'h02;
        2: begin op = 8'h03; val = 8'h00; end
        3: op = 8'h04;
        4: op = 8'h05;
        5: op = 8'(8'h81 + $urandom_range(0, 4));
        6: op = 8'($urandom_range(6, 127));
        default: op = 8'($urandom_range(1, 5));
      endcase
      if (op == 8'h03) val = 8'h00;
      ck = op ^ val;
      if ($urandom_range(0, 7) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      apply_frame(op, val, ck, 0);
      wait_cyc($urandom_range(0, 40));
    end
    wait_cyc(20);
    check("rand_err_total", err_seen, err_exp);

    // Reset mid-frame while running TRI.
    apply_frame(8'h01, 8'h01, 8'h00, 0);
    apply_frame(8'h02, 8'h10, 8'h12, 0);
    apply_frame(8'h05, 8'hFF, 8'hFA, 0);
    apply_frame(8'h03, 8'h00, 8'h03, 0);
    apply_frame(8'h04, 8'h02, 8'h06, 0);
    wait_cyc(30);
    check("pre_rst_dac_nz", dac_out != 0, 1);
    send_byte(8'hA5); send_byte(8'h01);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_dac", dac_out, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    model_reset();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2100);
    base_tx = tx_seen;
    apply_frame(8'h02, 8'h05, 8'h07, 0);
    wait_cyc(20);
    check("post_rst_ack", tx_seen - base_tx, 1);
    check("rsp_all_sent", rsp_rd, exp_rsp.size());
    check("err_total", err_seen, err_exp);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
